// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if
//   Bundles the game-logic / scan-position inputs and the per-pixel draw
//   results of sprite_renderer.
//   master : drives sprite records and the scan position, reads draw results
//   slave  : sprite_renderer itself
//   Signals:
//     sprites_i          N_SPRITES packed records {x_pos, y_pos, right, bottom}
//     frame_start_i      1-cycle pulse in vertical blank
//     pixel_valid_i      display enable qualifying x_i / y_i
//     x_i, y_i           current scan position
//     pixel_valid_o      pixel_valid_i delayed by the pipeline
//     layer_o            0 bg, 1 border, 2 separator, 3 sprite
//     sprite_hit_o       mask of sprites covering the pixel
//     sprite_id_o        lowest index set in sprite_hit_o
//     collision_o        sprites that overlapped during the previous frame
//     collision_valid_o  1-cycle pulse when collision_o is refreshed
interface sprite_renderer_if #(
   parameter int unsigned N_SPRITES = 3,
   parameter int unsigned X_POS_W   = 10,
   parameter int unsigned Y_POS_W   = 10
);
   localparam int unsigned SPRITE_W = 2 * X_POS_W + 2 * Y_POS_W;
   localparam int unsigned ID_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

   logic [N_SPRITES-1:0][SPRITE_W-1:0] sprites_i;
   logic                               frame_start_i;
   logic                               pixel_valid_i;
   logic [X_POS_W-1:0]                 x_i;
   logic [Y_POS_W-1:0]                 y_i;

   logic                               pixel_valid_o;
   logic [1:0]                         layer_o;
   logic [N_SPRITES-1:0]               sprite_hit_o;
   logic [ID_W-1:0]                    sprite_id_o;
   logic [N_SPRITES-1:0]               collision_o;
   logic                               collision_valid_o;

   modport master (
      output sprites_i, frame_start_i, pixel_valid_i, x_i, y_i,
      input  pixel_valid_o, layer_o, sprite_hit_o, sprite_id_o,
             collision_o, collision_valid_o
   );

   modport slave (
      input  sprites_i, frame_start_i, pixel_valid_i, x_i, y_i,
      output pixel_valid_o, layer_o, sprite_hit_o, sprite_id_o,
             collision_o, collision_valid_o
   );
endinterface

// File: rtl/sprite_renderer.sv
// sprite_renderer
//   Reader side of the sprite position bus. Snapshots sprite records once per
//   frame, classifies every displayed pixel as background / border / centre
//   separator / sprite, reports which sprites cover the pixel and which
//   sprites overlapped each other during the previous frame.
//   Two-stage pipeline, one pixel per clock, no stall:
//     S1 registers the per-sprite x/y range compares, border, separator, valid
//     S2 resolves priority and registers all outputs
//   Ports:
//     clk_i  pixel clock
//     rst_i  asynchronous reset, active high
//     bus    sprite_renderer_if.slave (scan inputs, sprite records, results)
module sprite_renderer #(
   parameter int unsigned N_SPRITES            = 3,
   parameter int unsigned X_POS_W              = 10,
   parameter int unsigned Y_POS_W              = 10,
   parameter int unsigned SCREEN_H_RES         = 640,
   parameter int unsigned SCREEN_V_RES         = 480,
   parameter int unsigned SCREEN_BORDER        = 10,
   parameter int unsigned SEPARATOR_WIDTH      = 6,
   parameter int unsigned SEPARATOR_DOT_HEIGHT = 18
) (
   input  logic             clk_i,
   input  logic             rst_i,
   sprite_renderer_if.slave bus
);

   localparam int unsigned SPRITE_W = 2 * X_POS_W + 2 * Y_POS_W;
   localparam int unsigned ID_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam int unsigned CNT_W    = (SEPARATOR_DOT_HEIGHT > 1) ? $clog2(SEPARATOR_DOT_HEIGHT) : 1;

   // Field positions inside a record {x_pos, y_pos, right, bottom}
   localparam int unsigned B_LSB = 0;
   localparam int unsigned R_LSB = Y_POS_W;
   localparam int unsigned Y_LSB = Y_POS_W + X_POS_W;
   localparam int unsigned X_LSB = 2 * Y_POS_W + X_POS_W;

   localparam logic [X_POS_W-1:0] SEP_LO     = X_POS_W'(SCREEN_H_RES / 2 - SEPARATOR_WIDTH / 2);
   localparam logic [X_POS_W-1:0] SEP_HI     = X_POS_W'(SCREEN_H_RES / 2 + SEPARATOR_WIDTH / 2);
   localparam logic [Y_POS_W-1:0] BORDER_TOP = Y_POS_W'(SCREEN_BORDER);
   localparam logic [Y_POS_W-1:0] BORDER_BOT = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SEPARATOR_DOT_HEIGHT - 1);

   typedef enum logic {
      DASH_OFF = 1'b0,
      DASH_ON  = 1'b1
   } dash_state_t;

   typedef enum logic [1:0] {
      LAYER_BG     = 2'd0,
      LAYER_BORDER = 2'd1,
      LAYER_SEP    = 2'd2,
      LAYER_SPRITE = 2'd3
   } layer_t;

   // Frame snapshot of the sprite records
   logic [N_SPRITES-1:0][SPRITE_W-1:0] shadow_q, shadow_d;

   // Dash generator
   dash_state_t          dash_q, dash_d;
   logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
   logic                 pv_prev_q, pv_prev_d;

   // Stage 1
   logic                 s1_valid_q, s1_valid_d;
   logic [N_SPRITES-1:0] s1_x_in_q, s1_x_in_d;
   logic [N_SPRITES-1:0] s1_y_in_q, s1_y_in_d;
   logic                 s1_border_q, s1_border_d;
   logic                 s1_sep_q, s1_sep_d;

   // Stage 2 (outputs)
   logic                 pv_o_q, pv_o_d;
   layer_t               layer_q, layer_d;
   logic [N_SPRITES-1:0] hit_q, hit_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic                 id_found;

   // Collision tracking
   logic [N_SPRITES-1:0] acc_q, acc_d;
   logic [N_SPRITES-1:0] coll_q, coll_d;
   logic                 coll_valid_q, coll_valid_d;
   logic                 armed_q, armed_d;
   logic [N_SPRITES-1:0] coll_contrib;

   // Snapshot: a pixel coinciding with frame_start_i still sees the old shadow
   // because S1 compares against shadow_q.
   always_comb begin
      shadow_d = shadow_q;
      if (bus.frame_start_i) begin
         shadow_d = bus.sprites_i;
      end
   end

   // Dash generator: counts line ends (falling edge of pixel_valid_i);
   // frame_start_i takes precedence over a coincident line end.
   always_comb begin
      dash_d     = dash_q;
      line_cnt_d = line_cnt_q;
      pv_prev_d  = bus.pixel_valid_i;
      if (bus.frame_start_i) begin
         dash_d     = DASH_ON;
         line_cnt_d = '0;
      end else if (pv_prev_q && !bus.pixel_valid_i) begin
         if (line_cnt_q == CNT_LAST) begin
            line_cnt_d = '0;
            dash_d     = (dash_q == DASH_ON) ? DASH_OFF : DASH_ON;
         end else begin
            line_cnt_d = line_cnt_q + CNT_W'(1);
         end
      end
   end

   // Stage 1: half-open range compares; right <= x_pos (or bottom <= y_pos)
   // can never satisfy both bounds, so empty records never hit.
   always_comb begin
      s1_valid_d = bus.pixel_valid_i;
      s1_x_in_d  = '0;
      s1_y_in_d  = '0;
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
         s1_x_in_d[i] = (bus.x_i >= shadow_q[i][X_LSB +: X_POS_W]) &&
                        (bus.x_i <  shadow_q[i][R_LSB +: X_POS_W]);
         s1_y_in_d[i] = (bus.y_i >= shadow_q[i][Y_LSB +: Y_POS_W]) &&
                        (bus.y_i <  shadow_q[i][B_LSB +: Y_POS_W]);
      end
      s1_border_d = (bus.y_i < BORDER_TOP) || (bus.y_i >= BORDER_BOT);
      s1_sep_d    = (dash_q == DASH_ON) && (bus.x_i >= SEP_LO) && (bus.x_i < SEP_HI);
   end

   // Stage 2: priority resolution; everything is zero for non-displayed pixels
   always_comb begin
      pv_o_d   = s1_valid_q;
      hit_d    = s1_valid_q ? (s1_x_in_q & s1_y_in_q) : '0;
      id_d     = '0;
      id_found = 1'b0;
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
         if (hit_d[i] && !id_found) begin
            id_d     = ID_W'(i);
            id_found = 1'b1;
         end
      end
      layer_d = LAYER_BG;
      if (s1_valid_q) begin
         if (hit_d != '0) begin
            layer_d = LAYER_SPRITE;
         end else if (s1_sep_q) begin
            layer_d = LAYER_SEP;
         end else if (s1_border_q) begin
            layer_d = LAYER_BORDER;
         end
      end
   end

   // Collision: x & (x-1) is non-zero exactly when two or more bits are set.
   // The first frame_start_i after reset only arms the reporting, so a frame
   // cut short by reset never produces a pulse.
   always_comb begin
      coll_contrib = ((hit_d & (hit_d - N_SPRITES'(1))) != '0) ? hit_d : '0;
      acc_d        = acc_q | coll_contrib;
      coll_d       = coll_q;
      coll_valid_d = 1'b0;
      armed_d      = armed_q;
      if (bus.frame_start_i) begin
         acc_d   = '0;
         armed_d = 1'b1;
         if (armed_q) begin
            coll_d       = acc_q | coll_contrib;
            coll_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q     <= '0;
         dash_q       <= DASH_OFF;
         line_cnt_q   <= '0;
         pv_prev_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_x_in_q    <= '0;
         s1_y_in_q    <= '0;
         s1_border_q  <= 1'b0;
         s1_sep_q     <= 1'b0;
         pv_o_q       <= 1'b0;
         layer_q      <= LAYER_BG;
         hit_q        <= '0;
         id_q         <= '0;
         acc_q        <= '0;
         coll_q       <= '0;
         coll_valid_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         dash_q       <= dash_d;
         line_cnt_q   <= line_cnt_d;
         pv_prev_q    <= pv_prev_d;
         s1_valid_q   <= s1_valid_d;
         s1_x_in_q    <= s1_x_in_d;
         s1_y_in_q    <= s1_y_in_d;
         s1_border_q  <= s1_border_d;
         s1_sep_q     <= s1_sep_d;
         pv_o_q       <= pv_o_d;
         layer_q      <= layer_d;
         hit_q        <= hit_d;
         id_q         <= id_d;
         acc_q        <= acc_d;
         coll_q       <= coll_d;
         coll_valid_q <= coll_valid_d;
         armed_q      <= armed_d;
      end
   end

   assign bus.pixel_valid_o     = pv_o_q;
   assign bus.layer_o           = layer_q;
   assign bus.sprite_hit_o      = hit_q;
   assign bus.sprite_id_o       = id_q;
   assign bus.collision_o       = coll_q;
   assign bus.collision_valid_o = coll_valid_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer
//   Directed bench for sprite_renderer. A frame-level model derives the
//   expected draw result of every pixel from the screen rules and a per-frame
//   overlap set; a compare process checks the DUT on every clock, and probe
//   points pin hand-computed values.
module tb_sprite_renderer;

   logic clk;
   logic rst;

   sprite_renderer_if #(.N_SPRITES(3), .X_POS_W(10), .Y_POS_W(10)) bus_if ();

   sprite_renderer #(
      .N_SPRITES(3), .X_POS_W(10), .Y_POS_W(10),
      .SCREEN_H_RES(640), .SCREEN_V_RES(480), .SCREEN_BORDER(10),
      .SEPARATOR_WIDTH(6), .SEPARATOR_DOT_HEIGHT(18)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pv;
      logic [1:0] layer;
      logic [2:0] hit;
      logic [1:0] id;
   } px_t;

   typedef struct packed {
      logic [2:0] c;
      logic       v;
   } coll_t;

   int n_vec = 0;
   int n_err = 0;

   px_t   cur_px  = '0;
   coll_t cur_coll = '0;
   px_t   st1 = '0;
   px_t   st2 = '0;
   coll_t cst = '0;

   // Model state
   int       live_x[3], live_y[3], live_r[3], live_b[3];
   int       sh_x[3], sh_y[3], sh_r[3], sh_b[3];
   int       line_no = 0;
   bit       frame_seen = 0;
   bit       prev_v = 0;
   bit       armed = 0;
   bit [2:0] acc = '0;
   bit [2:0] mcoll = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic px_t eval_px(input bit v, input int x, input int y);
      px_t p;
      bit  dash;
      p = '0;
      if (!v) return p;
      p.pv = 1'b1;
      for (int i = 0; i < 3; i++)
         if (x >= sh_x[i] && x < sh_r[i] && y >= sh_y[i] && y < sh_b[i]) p.hit[i] = 1'b1;
      for (int i = 2; i >= 0; i--)
         if (p.hit[i]) p.id = 2'(i);
      dash = frame_seen && (((line_no / 18) % 2) == 0);
      if (p.hit != 3'b000)                 p.layer = 2'd3;
      else if (dash && x >= 317 && x < 323) p.layer = 2'd2;
      else if (y < 10 || y >= 470)          p.layer = 2'd1;
      return p;
   endfunction

   task automatic model_step(input bit fs, input bit v, input int x, input int y);
      px_t      p;
      coll_t    c;
      bit [2:0] contrib;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_r[i] = 0; sh_b[i] = 0;
         end
         line_no = 0; frame_seen = 0; prev_v = 0; armed = 0;
         acc = '0; mcoll = '0;
         cur_px = '0; cur_coll = '0;
         return;
      end
      p = eval_px(v, x, y);
      contrib = ($countones(p.hit) >= 2) ? p.hit : 3'b000;
      c = '0;
      if (fs) begin
         if (armed) begin
            mcoll = acc;
            c.v   = 1'b1;
         end
         acc = '0; armed = 1; line_no = 0; frame_seen = 1;
         for (int i = 0; i < 3; i++) begin
            sh_x[i] = live_x[i]; sh_y[i] = live_y[i]; sh_r[i] = live_r[i]; sh_b[i] = live_b[i];
         end
      end else if (prev_v && !v) begin
         line_no++;
      end
      acc    = acc | contrib;
      prev_v = v;
      c.c    = mcoll;
      cur_px   = p;
      cur_coll = c;
   endtask

   task automatic step(input bit fs, input bit v, input int x, input int y);
      @(negedge clk);
      bus_if.frame_start_i = fs;
      bus_if.pixel_valid_i = v;
      bus_if.x_i = 10'(x);
      bus_if.y_i = 10'(y);
      model_step(fs, v, x, y);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic set_sprite(input int i, input int x, input int y, input int r, input int b);
      live_x[i] = x; live_y[i] = y; live_r[i] = r; live_b[i] = b;
      bus_if.sprites_i[i] = {10'(x), 10'(y), 10'(r), 10'(b)};
   endtask

   // One pixel, then two idle cycles so its result sits on the outputs
   task automatic probe(input string name, input int x, input int y,
                        input int eh, input int eid, input int el);
      step(1'b0, 1'b1, x, y);
      idle(2);
      chk({name, " valid"}, int'(bus_if.pixel_valid_o), 1);
      chk({name, " hit"},   int'(bus_if.sprite_hit_o), eh);
      chk({name, " id"},    int'(bus_if.sprite_id_o), eid);
      chk({name, " layer"}, int'(bus_if.layer_o), el);
   endtask

   // Cycle-by-cycle compare: pixel results two clocks after input,
   // collision results one clock after frame_start_i.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            st1 = '0; st2 = '0; cst = '0;
         end else begin
            st2 = st1; st1 = cur_px; cst = cur_coll;
         end
         #1;
         chk("pixel_valid_o",     int'(bus_if.pixel_valid_o),     int'(st2.pv));
         chk("layer_o",           int'(bus_if.layer_o),           int'(st2.layer));
         chk("sprite_hit_o",      int'(bus_if.sprite_hit_o),      int'(st2.hit));
         chk("sprite_id_o",       int'(bus_if.sprite_id_o),       int'(st2.id));
         chk("collision_o",       int'(bus_if.collision_o),       int'(cst.c));
         chk("collision_valid_o", int'(bus_if.collision_valid_o), int'(cst.v));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
      $fatal(1);
   end

   int sep_x[8] = '{316, 318, 319, 320, 321, 322, 323, 317};

   initial begin
      rst = 1'b1;
      bus_if.frame_start_i = 1'b0;
      bus_if.pixel_valid_i = 1'b0;
      bus_if.x_i = '0;
      bus_if.y_i = '0;
      bus_if.sprites_i = '0;
      for (int i = 0; i < 3; i++) begin
         live_x[i] = 0; live_y[i] = 0; live_r[i] = 0; live_b[i] = 0;
         sh_x[i] = 0; sh_y[i] = 0; sh_r[i] = 0; sh_b[i] = 0;
      end

      // Reset held while pixels are scanned
      set_sprite(2, 315, 235, 325, 245);
      step(1'b0, 1'b1, 320, 240);
      step(1'b0, 1'b1, 320, 5);
      step(1'b1, 1'b1, 318, 240);
      step(1'b0, 1'b1, 600, 300);
      chk("reset valid", int'(bus_if.pixel_valid_o), 0);
      chk("reset layer", int'(bus_if.layer_o), 0);
      chk("reset hit",   int'(bus_if.sprite_hit_o), 0);
      chk("reset cvalid", int'(bus_if.collision_valid_o), 0);
      idle(1);
      @(negedge clk);
      rst = 1'b0;

      // Ball frame
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("first fs no pulse", int'(bus_if.collision_valid_o), 0);
      for (int x = 314; x <= 325; x++) step(1'b0, 1'b1, x, 235);
      idle(2);
      probe("ball x314", 314, 235, 0, 0, 0);
      probe("ball x315", 315, 235, 4, 2, 3);
      probe("ball x324", 324, 235, 4, 2, 3);
      probe("ball x325", 325, 235, 0, 0, 0);

      // Live change mid-frame stays invisible until frame_start_i
      set_sprite(2, 100, 100, 110, 110);
      probe("stale shadow", 320, 235, 4, 2, 3);
      step(1'b1, 1'b1, 320, 235);
      idle(2);
      chk("fs same-cycle hit",   int'(bus_if.sprite_hit_o), 4);
      chk("fs same-cycle layer", int'(bus_if.layer_o), 3);
      probe("new shadow", 105, 105, 4, 2, 3);
      probe("old pos gone", 320, 235, 0, 0, 2);

      // Player / ball overlap
      set_sprite(0, 610, 215, 620, 265);
      set_sprite(2, 605, 235, 615, 245);
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("empty frame pulse", int'(bus_if.collision_valid_o), 1);
      chk("empty frame coll",  int'(bus_if.collision_o), 0);
      probe("overlap", 612, 240, 5, 0, 3);
      for (int x = 600; x <= 625; x++) step(1'b0, 1'b1, x, 240);
      idle(3);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("coll pulse", int'(bus_if.collision_valid_o), 1);
      chk("coll mask",  int'(bus_if.collision_o), 5);
      idle(1);
      chk("coll pulse end", int'(bus_if.collision_valid_o), 0);
      chk("coll held",      int'(bus_if.collision_o), 5);
      probe("clean frame", 100, 300, 0, 0, 0);
      for (int i = 0; i < 3; i++) set_sprite(i, 0, 0, 0, 0);
      idle(1);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("clean pulse", int'(bus_if.collision_valid_o), 1);
      chk("clean coll",  int'(bus_if.collision_o), 0);

      // Separator dashes over 60 lines
      for (int ln = 0; ln < 60; ln++) begin
         for (int k = 0; k < 8; k++) step(1'b0, 1'b1, sep_x[k], ln);
         idle(2);
         case (ln)
            0, 17, 36, 53: chk("sep on line",  int'(bus_if.layer_o), 2);
            18, 35, 54:    chk("sep off line", int'(bus_if.layer_o), 0);
            default: ;
         endcase
      end
      probe("border y5", 100, 5, 0, 0, 1);
      probe("sep left outside", 316, 240, 0, 0, 0);

      // Reset mid-line with an overlap pending
      set_sprite(0, 610, 215, 620, 265);
      set_sprite(2, 605, 235, 615, 245);
      idle(1);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      step(1'b0, 1'b1, 612, 240);
      step(1'b0, 1'b1, 613, 240);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", int'(bus_if.pixel_valid_o), 0);
      chk("async rst hit",   int'(bus_if.sprite_hit_o), 0);
      chk("async rst layer", int'(bus_if.layer_o), 0);
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      probe("no shadow after rst", 612, 240, 0, 0, 0);
      idle(1);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("no pulse after rst", int'(bus_if.collision_valid_o), 0);
      probe("render resumes", 612, 240, 5, 0, 3);
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      chk("pulse after resume", int'(bus_if.collision_valid_o), 1);
      chk("coll after resume",  int'(bus_if.collision_o), 5);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
